// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
// FSM state encoding and requester identity.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_BURST = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares one combinational I-memory port between I-cache
// refill bursts and single-word data-side reads.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int LW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  burst_req,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic [LW-1:0]         burst_len,
  output logic                  burst_gnt,
  output logic                  burst_valid,
  output logic                  burst_last,
  output logic [DATA_WIDTH-1:0] burst_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            r_state;
  arb_state_e            w_next;
  req_id_e               r_last;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_cnt;
  logic                  r_bvalid;
  logic                  r_blast;
  logic                  r_dvalid;
  logic [DATA_WIDTH-1:0] r_brdata;
  logic [DATA_WIDTH-1:0] r_drdata;
  logic                  w_issue;
  logic                  w_final;
  logic                  w_take_b;
  logic                  w_take_d;
  logic                  w_unused;

  // Refills are word aligned; the low address bits are dropped.
  assign w_unused = ^burst_addr[1:0];
  assign w_final  = (r_cnt == r_len);

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    burst_gnt = 1'b0;
    d_gnt     = 1'b0;
    w_issue   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (burst_req &&
            (!d_req || r_last == REQ_DATA))
          w_next = S_BURST;
        else if (d_req)
          w_next = S_DATA;
      end
      S_BURST: begin
        mem_addr  = r_base
                  + (ADDR_WIDTH'(r_cnt) << 2);
        burst_gnt = (r_cnt == '0);
        w_issue   = 1'b1;
        if (w_final)
          w_next = d_req ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        mem_addr = d_addr;
        d_gnt    = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_take_b = (r_state == S_IDLE)
                 && (w_next == S_BURST);
  assign w_take_d = (w_next == S_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= REQ_DATA;
      r_base   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_bvalid <= 1'b0;
      r_blast  <= 1'b0;
      r_dvalid <= 1'b0;
      r_brdata <= '0;
      r_drdata <= '0;
    end else begin
      r_state  <= w_next;
      r_bvalid <= w_issue;
      r_blast  <= w_issue && w_final;
      r_dvalid <= d_gnt;
      if (w_issue)
        r_brdata <= mem_rdata;
      if (d_gnt)
        r_drdata <= mem_rdata;
      if (w_take_b) begin
        r_base <= {burst_addr[ADDR_WIDTH-1:2],
                   2'b00};
        r_len  <= burst_len;
        r_cnt  <= '0;
        r_last <= REQ_BURST;
      end else begin
        if (r_state == S_BURST)
          r_cnt <= r_cnt + LW'(1);
        if (w_take_d)
          r_last <= REQ_DATA;
      end
    end
  end

  assign burst_valid = r_bvalid;
  assign burst_last  = r_blast;
  assign burst_rdata = r_brdata;
  assign d_valid     = r_dvalid;
  assign d_rdata     = r_drdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter.
// Beat/read data is predicted from a fixed memory function.
module tb_imem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          burst_req = 1'b0;
  logic [AW-1:0] burst_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic          burst_gnt;
  logic          burst_valid;
  logic          burst_last;
  logic [DW-1:0] burst_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  imem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .burst_req  (burst_req),
    .burst_addr (burst_addr),
    .burst_len  (burst_len),
    .burst_gnt  (burst_gnt),
    .burst_valid(burst_valid),
    .burst_last (burst_last),
    .burst_rdata(burst_rdata),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_gnt      (d_gnt),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(
    input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  always_comb mem_rdata = memf(mem_addr);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       bq[$];
  logic [31:0] dq[$];
  int          n_tot = 0;
  int          n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    beat_t       e;
    logic [31:0] de;
    if (burst_valid) begin
      if (bq.size() == 0) begin
        chk("b_unexp", 1, 0);
      end else begin
        e = bq.pop_front();
        chk("b_data", burst_rdata, e.data);
        chk("b_last", burst_last, e.last);
      end
    end else if (burst_last) begin
      chk("b_last_alone", 1, 0);
    end
    if (d_valid) begin
      if (dq.size() == 0) begin
        chk("d_unexp", 1, 0);
      end else begin
        de = dq.pop_front();
        chk("d_data", d_rdata, de);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_bg"}, burst_gnt, 0);
    chk({tag, "_bv"}, burst_valid, 0);
    chk({tag, "_bl"}, burst_last, 0);
    chk({tag, "_dg"}, d_gnt, 0);
    chk({tag, "_dv"}, d_valid, 0);
    chk({tag, "_ma"}, mem_addr, 0);
  endtask

  // Issues one burst; returns in the cycle after
  // the last beat address.
  task automatic do_burst(input logic [31:0] a,
                          input logic [2:0] len);
    logic [31:0] base;
    logic [31:0] ea;
    base = a & 32'hFFFF_FFFC;
    burst_req  = 1'b1;
    burst_addr = a;
    burst_len  = len;
    tick();
    burst_req  = 1'b0;
    burst_addr = 32'hDEAD_BEE0;
    burst_len  = ~len;
    for (int i = 0; i <= int'(len); i++) begin
      ea = base + 32'(i) * 4;
      chk("b_gnt", burst_gnt, i == 0);
      chk("b_addr", mem_addr, ea);
      chk("b_vld", burst_valid, i != 0);
      chk("b_dgnt", d_gnt, 0);
      bq.push_back(beat_t'{memf(ea),
                           i == int'(len)});
      tick();
    end
    chk("b_tail_v", burst_valid, 1);
    chk("b_tail_l", burst_last, 1);
    chk("b_tail_g", burst_gnt, 0);
  endtask

  initial begin
    do_reset();
    chk_quiet("rst");
    chk("rst_brd", burst_rdata, 0);
    chk("rst_drd", d_rdata, 0);
    tick();
    chk_quiet("idle");

    // Plain 8-beat burst at 0x100
    do_burst(32'h100, 3'd7);
    tick();
    chk_quiet("b1_end");

    // Address wraps past the top of memory
    do_burst(32'hFFFF_FFF8, 3'd3);
    tick();
    chk_quiet("wrap_end");

    // Single beat, unaligned base
    do_burst(32'h203, 3'd0);
    tick();
    chk_quiet("one_end");

    // Data read alone
    d_req  = 1'b1;
    d_addr = 32'h2A;
    tick();
    chk("d_gnt", d_gnt, 1);
    chk("d_addr", mem_addr, 32'h2A);
    chk("d_bg", burst_gnt, 0);
    dq.push_back(memf(32'h2A));
    d_req = 1'b0;
    tick();
    chk("d_vld", d_valid, 1);
    chk("d_gnt2", d_gnt, 0);
    chk("d_ma2", mem_addr, 0);
    tick();
    chk_quiet("d_end");

    // Tie after reset: burst first, data after
    do_reset();
    d_req  = 1'b1;
    d_addr = 32'h30;
    do_burst(32'h400, 3'd7);
    chk("tie_dgnt", d_gnt, 1);
    chk("tie_daddr", mem_addr, 32'h30);
    dq.push_back(memf(32'h30));
    d_req = 1'b0;
    tick();
    chk("tie_dvld", d_valid, 1);
    chk("tie_dgnt2", d_gnt, 0);
    tick();
    chk_quiet("tie_end");

    // Both held: grants alternate
    do_reset();
    burst_req  = 1'b1;
    burst_addr = 32'h800;
    burst_len  = 3'd1;
    d_req      = 1'b1;
    d_addr     = 32'h44;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("alt_bg", burst_gnt, 1);
      chk("alt_dg0", d_gnt, 0);
      chk("alt_a0", mem_addr, 32'h800);
      bq.push_back(beat_t'{memf(32'h800), 1'b0});
      tick();
      chk("alt_bg1", burst_gnt, 0);
      chk("alt_a1", mem_addr, 32'h804);
      bq.push_back(beat_t'{memf(32'h804), 1'b1});
      tick();
      chk("alt_dg", d_gnt, 1);
      chk("alt_ad", mem_addr, 32'h44);
      dq.push_back(memf(32'h44));
      tick();
      chk("alt_ibg", burst_gnt, 0);
      chk("alt_idg", d_gnt, 0);
      chk("alt_ia", mem_addr, 0);
    end
    burst_req = 1'b0;
    d_req     = 1'b0;
    tick();
    tick();
    chk_quiet("alt_end");

    // Reset during the third beat
    burst_req  = 1'b1;
    burst_addr = 32'h100;
    burst_len  = 3'd7;
    tick();
    bq.push_back(beat_t'{memf(32'h100), 1'b0});
    burst_req = 1'b0;
    tick();
    chk("ra_a1", mem_addr, 32'h104);
    bq.push_back(beat_t'{memf(32'h104), 1'b0});
    tick();
    chk("ra_a2", mem_addr, 32'h108);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("ra");
    chk("ra_brd", burst_rdata, 0);
    chk("ra_drd", d_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_quiet("ra_post");
    end

    chk("bq_left", bq.size(), 0);
    chk("dq_left", dq.size(), 0);
    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
